puf_test_sequencer: RTL and testbench

Parametrised on-chip statistical test sequencer for the arbiter PUF. It selects one of `N_CH` response channels and streams `BITS_PER_ROUND` response bits per round into the randomness test block. It accumulates per-test pass counts over `N_ROUNDS` rounds, then dumps the counts to result memory. It replaces the fixed 8-test, single-channel, 20000-bit test FSM and runs in the PUF test path between the challenge generator/PUF core and the result BRAM.

---
 rtl/puf_test_pkg.sv | 30 +++
 rtl/puf_test_sequencer_bank.sv | 53 +++++
 rtl/puf_test_sequencer.sv | 170 +++++++++++++++++
 tb/tb_puf_test_sequencer.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/puf_test_pkg.sv
// Shared types and helpers for the arbiter-PUF statistical test sequencer.
// Counter widths are derived from the run geometry by the helpers below.
package puf_test_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_COLLECT,
    S_SAMPLE,
    S_DUMP,
    S_DONE
  } seq_state_t;

  function automatic int cnt_w(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic [31:0] sat_inc(
    input logic [31:0] v,
    input logic [31:0] max_v,
    input logic        inc
  );
    return (inc && (v < max_v)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/puf_test_sequencer_bank.sv
// pass_counter_bank: one saturating pass counter per test, with a read mux.
// The read port returns the post-update value of the selected counter.
module pass_counter_bank
  import puf_test_pkg::*;
#(
  parameter int N_TESTS = 8,
  parameter int CNT_W   = 8,
  parameter int IDX_W   = idx_w(N_TESTS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               en,
  input  logic [N_TESTS-1:0] inc,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [CNT_W-1:0]   rd_data
);

  localparam logic [31:0] MAX_V = 32'((64'd1 << CNT_W) - 64'd1);

  logic [CNT_W-1:0] cnt_q [N_TESTS];
  logic [CNT_W-1:0] cnt_d [N_TESTS];

  always_comb begin
    for (int i = 0; i < N_TESTS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr) begin
        cnt_d[i] = '0;
      end else if (en) begin
        cnt_d[i] = CNT_W'(sat_inc(32'(cnt_q[i]), MAX_V, inc[i]));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_TESTS; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Reading cnt_d lets a dump entered straight from SAMPLE see the last round.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < N_TESTS; i++) begin
      if (IDX_W'(i) == rd_idx) rd_data = cnt_d[i];
    end
  end

endmodule

// File: rtl/puf_test_sequencer.sv
// PUF test sequencer: streams one channel into the test block, counts passes.
// Optional PUF_TEST_ABORT_EN adds an abort input that dumps partial counts.
module puf_test_sequencer
  import puf_test_pkg::*;
#(
  parameter int N_CH           = 4,
  parameter int N_TESTS        = 8,
  parameter int BITS_PER_ROUND = 20000,
  parameter int N_ROUNDS       = 255,
  parameter int CNT_W          = 8,
  parameter int ADDR_W         = 13
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [idx_w(N_CH)-1:0]   ch_sel,
  input  logic [N_CH-1:0]          resp,
  input  logic                     resp_valid,
`ifdef PUF_TEST_ABORT_EN
  input  logic                     abort,
`endif
  output logic                     chal_adv,
  output logic                     test_bit,
  output logic                     test_bit_valid,
  output logic                     test_clr,
  input  logic [N_TESTS-1:0]       test_result,
  output logic                     mem_we,
  output logic [ADDR_W-1:0]        mem_waddr,
  output logic [CNT_W-1:0]         mem_din,
  output logic                     busy,
  output logic                     done
);

  localparam int BIT_W = cnt_w(BITS_PER_ROUND);
  localparam int RND_W = cnt_w(N_ROUNDS);
  localparam int CH_W  = idx_w(N_CH);
  localparam int K_W   = idx_w(N_TESTS);

  if (N_TESTS > (1 << ADDR_W)) begin : g_addr_chk
    $error("N_TESTS does not fit the memory address space");
  end

  seq_state_t       state_q, state_d;
  logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [RND_W-1:0] rnd_cnt_q, rnd_cnt_d;
  logic [CH_W-1:0]  ch_q, ch_d;
  logic [K_W-1:0]   k_q, k_d;

  logic              chal_adv_d, test_bit_d, test_bit_valid_d, test_clr_d;
  logic              mem_we_d, busy_d, done_d;
  logic [ADDR_W-1:0] mem_waddr_d;
  logic [CNT_W-1:0]  mem_din_d;

  logic             bank_clr, bank_en;
  logic [CNT_W-1:0] bank_rd;

  pass_counter_bank #(
    .N_TESTS (N_TESTS),
    .CNT_W   (CNT_W),
    .IDX_W   (K_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .clr     (bank_clr),
    .en      (bank_en),
    .inc     (test_result),
    .rd_idx  (k_d),
    .rd_data (bank_rd)
  );

  always_comb begin
    state_d          = state_q;
    bit_cnt_d        = bit_cnt_q;
    rnd_cnt_d        = rnd_cnt_q;
    ch_d             = ch_q;
    k_d              = k_q;
    test_bit_d       = 1'b0;
    test_bit_valid_d = 1'b0;
    bank_clr         = 1'b0;
    bank_en          = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_INIT;
      end
      S_INIT: begin
        bit_cnt_d = '0;
        rnd_cnt_d = '0;
        bank_clr  = 1'b1;
        ch_d      = (32'(ch_sel) < N_CH) ? ch_sel : '0;
        state_d   = S_COLLECT;
      end
      S_COLLECT: begin
        if (resp_valid) begin
          test_bit_d       = resp[ch_q];
          test_bit_valid_d = 1'b1;
          bit_cnt_d        = bit_cnt_q + 1'b1;
          if (bit_cnt_d == BIT_W'(BITS_PER_ROUND)) state_d = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        bank_en   = 1'b1;
        bit_cnt_d = '0;
        rnd_cnt_d = rnd_cnt_q + 1'b1;
        state_d   = (rnd_cnt_d == RND_W'(N_ROUNDS)) ? S_DUMP : S_COLLECT;
      end
      S_DUMP: begin
        k_d = k_q + 1'b1;
        if (k_q == K_W'(N_TESTS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
`ifdef PUF_TEST_ABORT_EN
    if (abort && (state_q inside {S_INIT, S_COLLECT, S_SAMPLE})) begin
      state_d          = S_DUMP;
      test_bit_d       = 1'b0;
      test_bit_valid_d = 1'b0;
    end
`endif
    if ((state_d == S_DUMP) && (state_q != S_DUMP)) k_d = '0;
  end

  // Outputs follow the next state so they are registered alongside it.
  always_comb begin
    chal_adv_d  = (state_d == S_COLLECT);
    test_clr_d  = (state_d inside {S_INIT, S_SAMPLE});
    busy_d      = !(state_d inside {S_IDLE, S_DONE});
    done_d      = (state_d == S_DONE);
    mem_we_d    = (state_d == S_DUMP);
    mem_waddr_d = mem_we_d ? ADDR_W'(k_d) : '0;
    mem_din_d   = mem_we_d ? bank_rd : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= S_IDLE;
      bit_cnt_q      <= '0;
      rnd_cnt_q      <= '0;
      ch_q           <= '0;
      k_q            <= '0;
      chal_adv       <= 1'b0;
      test_bit       <= 1'b0;
      test_bit_valid <= 1'b0;
      test_clr       <= 1'b0;
      mem_we         <= 1'b0;
      mem_waddr      <= '0;
      mem_din        <= '0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      rnd_cnt_q      <= rnd_cnt_d;
      ch_q           <= ch_d;
      k_q            <= k_d;
      chal_adv       <= chal_adv_d;
      test_bit       <= test_bit_d;
      test_bit_valid <= test_bit_valid_d;
      test_clr       <= test_clr_d;
      mem_we         <= mem_we_d;
      mem_waddr      <= mem_waddr_d;
      mem_din        <= mem_din_d;
      busy           <= busy_d;
      done           <= done_d;
    end
  end

endmodule

// File: tb/tb_puf_test_sequencer.sv
// Randomized scoreboard bench for puf_test_sequencer.
// A run-schedule model predicts status, bit stream and dump contents.
module tb_puf_test_sequencer;

  localparam int N_CH     = 3;
  localparam int N_TESTS  = 8;
  localparam int BITS     = 16;
  localparam int N_ROUNDS = 5;
  localparam int CNT_W    = 2;
  localparam int ADDR_W   = 13;
  localparam int MAXC     = (1 << CNT_W) - 1;

  // {chal_adv, test_clr, busy, done}
  localparam logic [3:0] F_IDLE = 4'b0000;
  localparam logic [3:0] F_INIT = 4'b0110;
  localparam logic [3:0] F_COL  = 4'b1010;
  localparam logic [3:0] F_SMP  = 4'b0110;
  localparam logic [3:0] F_DUMP = 4'b0010;
  localparam logic [3:0] F_DONE = 4'b0001;

  logic clk = 1'b0;
  logic rst, start, resp_valid;
  logic [1:0] ch_sel;
  logic [N_CH-1:0] resp;
  logic [N_TESTS-1:0] test_result;
  logic chal_adv, test_bit, test_bit_valid, test_clr;
  logic mem_we, busy, done;
  logic [ADDR_W-1:0] mem_waddr;
  logic [CNT_W-1:0] mem_din;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic       zero;
    logic [3:0] flags;
  } stat_t;

  stat_t stat_q[$];
  logic bit_q[$];
  logic [ADDR_W+CNT_W-1:0] mem_q[$];

  always #5 clk = ~clk;

  puf_test_sequencer #(
    .N_CH(N_CH), .N_TESTS(N_TESTS), .BITS_PER_ROUND(BITS),
    .N_ROUNDS(N_ROUNDS), .CNT_W(CNT_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .ch_sel(ch_sel),
    .resp(resp),
    .resp_valid(resp_valid),
`ifdef PUF_TEST_ABORT_EN
    .abort(1'b0),
`endif
    .chal_adv(chal_adv),
    .test_bit(test_bit),
    .test_bit_valid(test_bit_valid),
    .test_clr(test_clr),
    .test_result(test_result),
    .mem_we(mem_we),
    .mem_waddr(mem_waddr),
    .mem_din(mem_din),
    .busy(busy),
    .done(done)
  );

  function automatic void check(input string nm, input logic [63:0] act,
                                input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic void unexpected(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: strobe with no expected entry at %0t", nm, $time);
  endfunction

  always @(negedge clk) begin : mon
    stat_t s;
    if (stat_q.size() > 0) begin
      s = stat_q.pop_front();
      check("status", 64'({chal_adv, test_clr, busy, done}), 64'(s.flags));
      if (s.zero)
        check("reset_outs",
              64'({test_bit, test_bit_valid, mem_we, mem_waddr, mem_din}), 64'd0);
    end
    if (test_bit_valid) begin
      if (bit_q.size() == 0) unexpected("test_bit");
      else check("test_bit", 64'(test_bit), 64'(bit_q.pop_front()));
    end
    if (mem_we) begin
      if (mem_q.size() == 0) unexpected("mem_write");
      else check("mem_write", 64'({mem_waddr, mem_din}), 64'(mem_q.pop_front()));
    end
  end

  task automatic step(input logic [3:0] flags, input logic zero = 1'b0);
    stat_q.push_back({zero, flags});
    @(posedge clk);
    #1;
  endtask

  // rv_mode: 0 valid always, 1 toggling, 2 random. rst_round<0: no reset.
  task automatic run_pass(input int chs, input int rv_mode, input bit fixed,
                          input int rst_round);
    logic [N_TESTS-1:0] tr [N_ROUNDS];
    int cnt [N_TESTS];
    int ch, acc;
    logic v, tog;
    ch = (chs < N_CH) ? chs : 0;
    for (int i = 0; i < N_TESTS; i++) cnt[i] = 0;
    for (int r = 0; r < N_ROUNDS; r++) begin
      tr[r] = fixed ? N_TESTS'(8'hA5) : N_TESTS'($urandom);
      for (int i = 0; i < N_TESTS; i++) cnt[i] += int'(tr[r][i]);
    end
    ch_sel = 2'(chs);
    start = 1'b1;
    resp = N_CH'($urandom);
    resp_valid = 1'($urandom);
    step(F_IDLE);
    start = 1'b0;
    resp_valid = 1'($urandom);
    step(F_INIT);
    for (int r = 0; r < N_ROUNDS; r++) begin
      test_result = tr[r];
      acc = 0;
      tog = 1'b1;
      while (acc < BITS) begin
        if (r == rst_round && acc == BITS / 2) begin
          rst = 1'b1;
          resp_valid = 1'b0;
          bit_q.delete();
          step(F_IDLE, 1'b1);
          rst = 1'b0;
          return;
        end
        case (rv_mode)
          0: v = 1'b1;
          1: begin v = tog; tog = ~tog; end
          default: v = 1'($urandom);
        endcase
        resp = N_CH'($urandom);
        resp_valid = v;
        if (v) bit_q.push_back(resp[ch]);
        step(F_COL);
        acc += int'(v);
      end
      resp = N_CH'($urandom);
      resp_valid = 1'($urandom);
      step(F_SMP);
    end
    for (int k = 0; k < N_TESTS; k++)
      mem_q.push_back({ADDR_W'(k), CNT_W'((cnt[k] > MAXC) ? MAXC : cnt[k])});
    resp_valid = 1'b0;
    for (int k = 0; k < N_TESTS; k++) step(F_DUMP);
  endtask

  task automatic done_phase(input int hold);
    for (int i = 0; i < hold; i++) begin
      start = 1'b1;
      step(F_DONE);
    end
    start = 1'b0;
    step(F_DONE);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    ch_sel = '0;
    resp = '0;
    resp_valid = 1'b0;
    test_result = '0;
    @(posedge clk);
    #1;
    step(F_IDLE, 1'b1);
    rst = 1'b0;
    step(F_IDLE);
    step(F_IDLE);
    run_pass(2, 0, 1'b1, -1);
    done_phase(0);
    run_pass(2, 1, 1'b0, -1);
    done_phase(0);
    run_pass(3, 2, 1'b0, 1);
    run_pass(3, 2, 1'b0, -1);
    done_phase(3);
    run_pass(1, 2, 1'b0, -1);
    done_phase(0);
    for (int i = 0; i < 4; i++) begin
      run_pass(int'($urandom_range(0, 3)), 2, 1'b0, -1);
      done_phase(int'($urandom_range(0, 2)));
    end
    step(F_IDLE);
    @(negedge clk);
    #1;
    check("bits_left", 64'(bit_q.size()), 64'd0);
    check("mem_left", 64'(mem_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
